// File: rtl/sram_82s21_ctl.sv
// ---------------------------------------------------------------------------
// sram_82s21_ctl
//
// Synchronous initiator for one 82S21-style 32x2 write-while-read bipolar RAM.
// Takes single-cycle read/write requests from the datapath and produces the
// RAM pin sequence: the address is latched by driving CE low, a read uses a
// STROBE pulse, and a write uses the per-bit WE_N lines with a WCLK_N pulse.
// Each completed operation produces a one-cycle rsp_valid pulse.
//
// Optional feature macro: SRAM_82S21_CTL_VERIFY_EN
//   When defined, every write is followed by a readback of the same word.
//   rsp_err flags any masked bit of the readback that differs from the
//   written data.
//   When not defined, writes end after the recovery cycle and rsp_err is 0.
//
// Parameters
//   STROBE_CYCLES  cycles STROBE is held high for a read          (1..15)
//   WE_CYCLES      cycles WE_N/WCLK_N are held low for a write     (1..15)
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   req_valid   request present
//   req_ready   controller idle; a request is accepted on valid && ready
//   req_we      1 = write, 0 = read
//   req_addr    word address
//   req_wdata   write data {bit1,bit0}
//   req_wmask   per-bit write enable (bit K drives ram_weK_n)
//   rsp_valid   one-cycle pulse: read data valid / write complete
//   rsp_rdata   last captured read data
//   rsp_err     readback mismatch, qualified by rsp_valid
//   ram_a       RAM address A4..A0
//   ram_i       RAM data inputs I1,I0
//   ram_ce      chip enable, active-low (address latches while low)
//   ram_we0_n   bit-0 write enable, active-low
//   ram_we1_n   bit-1 write enable, active-low
//   ram_wclk_n  write clock, active-low
//   ram_strobe  read strobe, active-high
//   ram_d       RAM data outputs D1,D0
// ---------------------------------------------------------------------------
module sram_82s21_ctl #(
   parameter int unsigned STROBE_CYCLES = 2,
   parameter int unsigned WE_CYCLES     = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_we,
   input  logic [4:0] req_addr,
   input  logic [1:0] req_wdata,
   input  logic [1:0] req_wmask,
   output logic       rsp_valid,
   output logic [1:0] rsp_rdata,
   output logic       rsp_err,
   output logic [4:0] ram_a,
   output logic [1:0] ram_i,
   output logic       ram_ce,
   output logic       ram_we0_n,
   output logic       ram_we1_n,
   output logic       ram_wclk_n,
   output logic       ram_strobe,
   input  logic [1:0] ram_d
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STRB,
      S_CAPT,
      S_WR,
      S_REC
   } state_t;

   // The down-counter is loaded with N-1 so that a phase lasts exactly N cycles.
   localparam logic [3:0] STRB_LOAD = 4'(STROBE_CYCLES - 1);
   localparam logic [3:0] WE_LOAD   = 4'(WE_CYCLES - 1);

   state_t     state;
   logic [3:0] cnt;
   logic       op_we;
   logic [1:0] mask_q;

`ifdef SRAM_82S21_CTL_VERIFY_EN
   logic       err_q;
   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         op_we      <= 1'b0;
         mask_q     <= '0;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         ram_a      <= '0;
         ram_i      <= '0;
         ram_ce     <= 1'b1;
         ram_we0_n  <= 1'b1;
         ram_we1_n  <= 1'b1;
         ram_wclk_n <= 1'b1;
         ram_strobe <= 1'b0;
`ifdef SRAM_82S21_CTL_VERIFY_EN
         err_q      <= 1'b0;
`endif
      end else begin
         // Response strobes are single-cycle by default.
         rsp_valid <= 1'b0;
`ifdef SRAM_82S21_CTL_VERIFY_EN
         err_q     <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               // req_ready is always high here, so valid alone means accept.
               if (req_valid) begin
                  ram_a     <= req_addr;
                  ram_i     <= req_wdata;
                  mask_q    <= req_wmask;
                  op_we     <= req_we;
                  ram_ce    <= 1'b0;
                  req_ready <= 1'b0;
                  state     <= S_SETUP;
               end
            end

            S_SETUP: begin
               if (op_we) begin
                  cnt        <= WE_LOAD;
                  ram_wclk_n <= 1'b0;
                  ram_we0_n  <= ~mask_q[0];
                  ram_we1_n  <= ~mask_q[1];
                  state      <= S_WR;
               end else begin
                  cnt        <= STRB_LOAD;
                  ram_strobe <= 1'b1;
                  state      <= S_STRB;
               end
            end

            S_STRB: begin
               if (cnt == 4'd0) begin
                  ram_strobe <= 1'b0;
                  state      <= S_CAPT;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            S_CAPT: begin
               rsp_rdata <= ram_d;
               rsp_valid <= 1'b1;
               ram_ce    <= 1'b1;
               req_ready <= 1'b1;
               state     <= S_IDLE;
`ifdef SRAM_82S21_CTL_VERIFY_EN
               // Only a write readback can mismatch; ram_i still holds wdata.
               err_q     <= op_we & (|((ram_d ^ ram_i) & mask_q));
`endif
            end

            S_WR: begin
               if (cnt == 4'd0) begin
                  ram_wclk_n <= 1'b1;
                  ram_we0_n  <= 1'b1;
                  ram_we1_n  <= 1'b1;
                  state      <= S_REC;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            S_REC: begin
`ifdef SRAM_82S21_CTL_VERIFY_EN
               // CE stays low; readback reuses the read strobe/capture path.
               cnt        <= STRB_LOAD;
               ram_strobe <= 1'b1;
               state      <= S_STRB;
`else
               rsp_valid <= 1'b1;
               ram_ce    <= 1'b1;
               req_ready <= 1'b1;
               state     <= S_IDLE;
`endif
            end

            default: begin
               ram_ce     <= 1'b1;
               ram_we0_n  <= 1'b1;
               ram_we1_n  <= 1'b1;
               ram_wclk_n <= 1'b1;
               ram_strobe <= 1'b0;
               req_ready  <= 1'b1;
               state      <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_82s21_ctl.sv
// ---------------------------------------------------------------------------
// tb_sram_82s21_ctl
//
// Self-checking bench for sram_82s21_ctl. Two instances share clock and
// reset: dut (default timing) and dut2 (STROBE_CYCLES=1, WE_CYCLES=3).
// Each drives its own behavioural 32x2 RAM model. A select flag steers the
// request/observation signals to one instance at a time.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_82s21_ctl;

   logic       clk;
   logic       reset_n;
   logic       sel;
   logic       rv;
   logic       req_we;
   logic [4:0] req_addr;
   logic [1:0] req_wdata;
   logic [1:0] req_wmask;
   logic       stuck;
   logic       preload;

   // dut signals
   logic       req_valid, req_ready, rsp_valid, rsp_err;
   logic [1:0] rsp_rdata, ram_i, ram_d;
   logic [4:0] ram_a;
   logic       ram_ce, ram_we0_n, ram_we1_n, ram_wclk_n, ram_strobe;

   // dut2 signals
   logic       req_valid2, req_ready2, rsp_valid2, rsp_err2;
   logic [1:0] rsp_rdata2, ram_i2, ram_d2;
   logic [4:0] ram_a2;
   logic       ram_ce2, ram_we0_n2, ram_we1_n2, ram_wclk_n2, ram_strobe2;

   logic [1:0] mem  [32];
   logic [1:0] mem2 [32];

   int n_cmp = 0;
   int n_bad = 0;

   sram_82s21_ctl dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ram_a(ram_a), .ram_i(ram_i), .ram_ce(ram_ce),
      .ram_we0_n(ram_we0_n), .ram_we1_n(ram_we1_n), .ram_wclk_n(ram_wclk_n),
      .ram_strobe(ram_strobe), .ram_d(ram_d)
   );

   sram_82s21_ctl #(.STROBE_CYCLES(1), .WE_CYCLES(3)) dut2 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2),
      .ram_a(ram_a2), .ram_i(ram_i2), .ram_ce(ram_ce2),
      .ram_we0_n(ram_we0_n2), .ram_we1_n(ram_we1_n2), .ram_wclk_n(ram_wclk_n2),
      .ram_strobe(ram_strobe2), .ram_d(ram_d2)
   );

   // Request steering and observation mux.
   assign req_valid  = sel ? 1'b0 : rv;
   assign req_valid2 = sel ? rv : 1'b0;

   logic       m_ready, m_valid, m_err, m_ce, m_we0, m_we1, m_wclk, m_strobe;
   logic [1:0] m_rdata;
   logic [4:0] m_a;
   assign m_ready  = sel ? req_ready2  : req_ready;
   assign m_valid  = sel ? rsp_valid2  : rsp_valid;
   assign m_err    = sel ? rsp_err2    : rsp_err;
   assign m_rdata  = sel ? rsp_rdata2  : rsp_rdata;
   assign m_ce     = sel ? ram_ce2     : ram_ce;
   assign m_a      = sel ? ram_a2      : ram_a;
   assign m_we0    = sel ? ram_we0_n2  : ram_we0_n;
   assign m_we1    = sel ? ram_we1_n2  : ram_we1_n;
   assign m_wclk   = sel ? ram_wclk_n2 : ram_wclk_n;
   assign m_strobe = sel ? ram_strobe2 : ram_strobe;

   function automatic logic [1:0] pat(input int i);
      pat = 2'(i ^ (i >> 2));
   endfunction

   // Behavioural RAM: combinational read, bit write while WCLK_N and WEK_N low.
   assign ram_d  = stuck ? 2'b00 : mem[ram_a];
   assign ram_d2 = mem2[ram_a2];

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 32; i++) mem[i] <= pat(i);
      end else if (!ram_ce && !ram_wclk_n) begin
         if (!ram_we0_n) mem[ram_a][0] <= ram_i[0];
         if (!ram_we1_n) mem[ram_a][1] <= ram_i[1];
      end
   end

   always @(posedge clk) begin
      if (!ram_ce2 && !ram_wclk_n2) begin
         if (!ram_we0_n2) mem2[ram_a2][0] <= ram_i2[0];
         if (!ram_we1_n2) mem2[ram_a2][1] <= ram_i2[1];
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // One request on the selected instance. Latency counts edges after the
   // accept edge E0 up to the edge after which rsp_valid is seen.
   task automatic do_req(input logic we, input logic [4:0] addr, input logic [1:0] wd,
                         input logic [1:0] wm, input logic [1:0] rd, input logic chk_rd,
                         input logic exp_err);
      int s, w, lat, n, sc, w0, w1, wc, abad;
      logic got;
      s = sel ? 1 : 2;
      w = sel ? 3 : 2;
`ifdef SRAM_82S21_CTL_VERIFY_EN
      lat = we ? (3 + w + s) : (2 + s);
`else
      lat = we ? (2 + w) : (2 + s);
`endif
      @(negedge clk);
      check("req_ready_before", m_ready, 1);
      rv = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wmask = wm;
      @(posedge clk); #1;
      rv = 1'b0;
      n = 0; got = 1'b0; sc = 0; w0 = 0; w1 = 0; wc = 0; abad = 0;
      while (!got && n < 60) begin
         if (!m_ce && m_a != addr) abad++;
         if (m_strobe) sc++;
         if (!m_we0) w0++;
         if (!m_we1) w1++;
         if (!m_wclk) wc++;
         @(posedge clk); #1;
         n++;
         if (m_valid) got = 1'b1;
      end
      check("rsp_seen", got, 1);
      check("latency", n, lat);
      check("addr_stable_ce_low", abad, 0);
      check("wclk_low_cycles", wc, we ? w : 0);
      check("we0_low_cycles", w0, (we && wm[0]) ? w : 0);
      check("we1_low_cycles", w1, (we && wm[1]) ? w : 0);
`ifdef SRAM_82S21_CTL_VERIFY_EN
      check("strobe_cycles", sc, s);
`else
      check("strobe_cycles", sc, we ? 0 : s);
`endif
      if (chk_rd) check("rsp_rdata", m_rdata, rd);
      check("rsp_err", m_err, exp_err);
   endtask

   typedef struct {
      logic       we;
      logic [4:0] addr;
      logic [1:0] wdata;
      logic [1:0] wmask;
      logic [1:0] rdata;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int acc, rsp, cyc, last, hits;
      logic found;

      vecs[0]  = '{1'b1, 5'h13, 2'b10, 2'b11, 2'b00};
      vecs[1]  = '{1'b0, 5'h13, 2'b00, 2'b00, 2'b10};
      vecs[2]  = '{1'b1, 5'h03, 2'b11, 2'b11, 2'b00};
      vecs[3]  = '{1'b1, 5'h03, 2'b00, 2'b01, 2'b00};
      vecs[4]  = '{1'b0, 5'h03, 2'b00, 2'b00, 2'b10};
      vecs[5]  = '{1'b1, 5'h00, 2'b01, 2'b11, 2'b00};
      vecs[6]  = '{1'b0, 5'h00, 2'b00, 2'b00, 2'b01};
      vecs[7]  = '{1'b1, 5'h1F, 2'b11, 2'b11, 2'b00};
      vecs[8]  = '{1'b1, 5'h1F, 2'b00, 2'b00, 2'b00};
      vecs[9]  = '{1'b0, 5'h1F, 2'b00, 2'b00, 2'b11};
      vecs[10] = '{1'b1, 5'h1F, 2'b00, 2'b10, 2'b00};
      vecs[11] = '{1'b0, 5'h1F, 2'b00, 2'b00, 2'b01};

      sel = 1'b0; rv = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      req_wmask = '0; stuck = 1'b0; preload = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values.
      check("rst_req_ready", req_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_ram_a", ram_a, 0);
      check("rst_ram_i", ram_i, 0);
      check("rst_ram_ce", ram_ce, 1);
      check("rst_we_wclk", {ram_we0_n, ram_we1_n, ram_wclk_n}, 3'b111);
      check("rst_strobe", ram_strobe, 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Table-driven write/read vectors on the default instance.
      for (int i = 0; i < 12; i++)
         do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wmask,
                vecs[i].rdata, !vecs[i].we, 1'b0);

      // Back-to-back reads of a preloaded RAM with req_valid held high.
      @(negedge clk); preload = 1'b1;
      @(posedge clk); #1; preload = 1'b0;
      acc = 0; rsp = 0; cyc = 0; last = 0;
      req_we = 1'b0; req_addr = '0; rv = 1'b1;
      while ((acc < 32 || rsp < 32) && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (rsp_valid) begin
            check("b2b_data", rsp_rdata, pat(rsp));
            rsp++;
         end
         if (rv && req_ready) begin
            if (acc > 0) begin
               check("b2b_interval", cyc - last, 5);
               check("b2b_overlap_rsp", rsp_valid, 1);
            end
            last = cyc;
            acc++;
            @(posedge clk); #1;
            req_addr = 5'(acc);
            if (acc == 32) rv = 1'b0;
         end
      end
      rv = 1'b0;
      check("b2b_accepts", acc, 32);
      check("b2b_responses", rsp, 32);

      // Reset while a write has WE0_N low.
      @(negedge clk);
      rv = 1'b1; req_we = 1'b1; req_addr = 5'h07; req_wdata = 2'b01; req_wmask = 2'b01;
      @(posedge clk); #1; rv = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (!ram_we0_n) found = 1'b1;
      end
      check("mid_wr_reached", found, 1);
      #2 reset_n = 1'b0;
      #1;
      check("arst_ce", ram_ce, 1);
      check("arst_we_wclk", {ram_we0_n, ram_we1_n, ram_wclk_n}, 3'b111);
      check("arst_strobe", ram_strobe, 0);
      check("arst_ready", req_ready, 1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      hits = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid) hits++;
      end
      check("no_rsp_after_reset", hits, 0);
      check("ready_after_reset", req_ready, 1);

      // Alternate timing instance: strobe width 1, WCLK width 3.
      sel = 1'b1;
      do_req(1'b1, 5'h05, 2'b10, 2'b11, 2'b00, 1'b0, 1'b0);
      do_req(1'b0, 5'h05, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0);
      sel = 1'b0;

`ifdef SRAM_82S21_CTL_VERIFY_EN
      // Readback with data outputs stuck at 00.
      stuck = 1'b1;
      do_req(1'b1, 5'h09, 2'b01, 2'b11, 2'b00, 1'b1, 1'b1);
      do_req(1'b1, 5'h09, 2'b01, 2'b10, 2'b00, 1'b1, 1'b0);
      stuck = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
